// File: rtl/configurador_timer.sv
// Front-panel editor for the periodic timer: debounces three buttons and edits interval/on-time
// through a 3-state menu. Outputs registered; committed values change only when a session closes.
module configurador_timer #(
  parameter int DEBOUNCE_CICLOS  = 1000,
  parameter int INTERVALO_PADRAO = 10,
  parameter int TEMPO_PADRAO     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_mais,
  input  logic       btn_menos,
  output logic [4:0] intervalo_ligar,
  output logic [4:0] tempo_ligado,
  output logic [1:0] campo,
  output logic [4:0] valor_edicao,
  output logic       atualizado
);

  localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CICLOS - 1);
  localparam logic [4:0]  INT_RST = 5'(INTERVALO_PADRAO);
  localparam logic [4:0]  TMP_RST = 5'(TEMPO_PADRAO);

  localparam logic [1:0] EXIBE           = 2'd0;
  localparam logic [1:0] EDITA_INTERVALO = 2'd1;
  localparam logic [1:0] EDITA_TEMPO     = 2'd2;

  logic [2:0] btn_raw;
  logic [2:0] pulso;

  assign btn_raw = {btn_menos, btn_mais, btn_modo};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic        s1;
    logic        s2;
    logic        deb;
    logic        deb_anterior;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1           <= 1'b0;
        s2           <= 1'b0;
        deb          <= 1'b0;
        deb_anterior <= 1'b0;
        cnt          <= 16'd0;
      end else begin
        s1           <= btn_raw[g];
        s2           <= s1;
        deb_anterior <= deb;
        if (s2 == deb) begin
          cnt <= 16'd0;
        end else if (cnt == DEB_MAX) begin
          deb <= s2;
          cnt <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end

    assign pulso[g] = deb & ~deb_anterior;
  end

  logic       modo;
  logic       sobe;
  logic       desce;
  logic [4:0] sombra_int;
  logic [4:0] sombra_tmp;
  logic [4:0] sombra_int_nxt;
  logic [4:0] sombra_tmp_nxt;
  logic [4:0] intervalo_nxt;
  logic [4:0] tempo_nxt;
  logic [1:0] campo_nxt;
  logic [4:0] valor_nxt;
  logic       atualizado_nxt;

  // mais and menos together cancel out; modo overrides both
  assign modo  = pulso[0];
  assign sobe  = pulso[1] & ~pulso[2];
  assign desce = pulso[2] & ~pulso[1];

  function automatic logic [4:0] satura(input logic [4:0] v, input logic up,
                                        input logic [5:0] minimo);
    logic [5:0] r;
    if (up) begin
      r = {1'b0, v} + 6'd1;
      if (r > 6'd31) r = 6'd31;
    end else if ({1'b0, v} <= minimo) begin
      r = minimo;
    end else begin
      r = {1'b0, v} - 6'd1;
    end
    return r[4:0];
  endfunction

  always_comb begin
    sombra_int_nxt = sombra_int;
    sombra_tmp_nxt = sombra_tmp;
    intervalo_nxt  = intervalo_ligar;
    tempo_nxt      = tempo_ligado;
    campo_nxt      = campo;
    atualizado_nxt = 1'b0;
    case (campo)
      EXIBE: begin
        if (modo) begin
          sombra_int_nxt = intervalo_ligar;
          sombra_tmp_nxt = tempo_ligado;
          campo_nxt      = EDITA_INTERVALO;
        end
      end
      EDITA_INTERVALO: begin
        if (modo) campo_nxt = EDITA_TEMPO;
        else if (sobe | desce) sombra_int_nxt = satura(sombra_int, sobe, 6'd1);
      end
      EDITA_TEMPO: begin
        if (modo) begin
          intervalo_nxt  = sombra_int;
          tempo_nxt      = sombra_tmp;
          atualizado_nxt = 1'b1;
          campo_nxt      = EXIBE;
        end else if (sobe | desce) begin
          sombra_tmp_nxt = satura(sombra_tmp, sobe, 6'd0);
        end
      end
      default: campo_nxt = EXIBE;
    endcase

    // display is registered from next-state values so it tracks the shadow without lag
    case (campo_nxt)
      EDITA_INTERVALO: valor_nxt = sombra_int_nxt;
      EDITA_TEMPO:     valor_nxt = sombra_tmp_nxt;
      default:         valor_nxt = intervalo_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sombra_int      <= INT_RST;
      sombra_tmp      <= TMP_RST;
      intervalo_ligar <= INT_RST;
      tempo_ligado    <= TMP_RST;
      campo           <= EXIBE;
      valor_edicao    <= INT_RST;
      atualizado      <= 1'b0;
    end else begin
      sombra_int      <= sombra_int_nxt;
      sombra_tmp      <= sombra_tmp_nxt;
      intervalo_ligar <= intervalo_nxt;
      tempo_ligado    <= tempo_nxt;
      campo           <= campo_nxt;
      valor_edicao    <= valor_nxt;
      atualizado      <= atualizado_nxt;
    end
  end

endmodule

// File: tb/tb_configurador_timer.sv
// Bench for configurador_timer: directed and random button presses checked against
// a press-level reference model of the menu.
module tb_configurador_timer;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_modo, btn_mais, btn_menos;
  logic [4:0] intervalo_ligar, tempo_ligado, valor_edicao;
  logic [1:0] campo;
  logic       atualizado;

  always #5 clk = ~clk;

  configurador_timer #(
    .DEBOUNCE_CICLOS(D),
    .INTERVALO_PADRAO(10),
    .TEMPO_PADRAO(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_modo(btn_modo),
    .btn_mais(btn_mais),
    .btn_menos(btn_menos),
    .intervalo_ligar(intervalo_ligar),
    .tempo_ligado(tempo_ligado),
    .campo(campo),
    .valor_edicao(valor_edicao),
    .atualizado(atualizado)
  );

  int n_chk = 0;
  int n_fail = 0;
  int upd_seen = 0;

  int m_int, m_tmp, m_campo, m_sint, m_stmp;
  int m_upd = 0;

  always @(posedge clk) begin
    #1;
    if (atualizado === 1'b1) upd_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_int = 10; m_tmp = 3; m_campo = 0; m_sint = 10; m_stmp = 3;
  endtask

  task automatic model_press(input bit mo, input bit ma, input bit me);
    if (mo) begin
      if (m_campo == 0) begin
        m_sint = m_int; m_stmp = m_tmp; m_campo = 1;
      end else if (m_campo == 1) begin
        m_campo = 2;
      end else begin
        m_int = m_sint; m_tmp = m_stmp; m_upd++; m_campo = 0;
      end
    end else if (ma != me) begin
      if (m_campo == 1) m_sint = clamp(m_sint + (ma ? 1 : -1), 1, 31);
      else if (m_campo == 2) m_stmp = clamp(m_stmp + (ma ? 1 : -1), 0, 31);
    end
  endtask

  task automatic check_all(input string tag);
    int v;
    v = (m_campo == 0) ? m_int : (m_campo == 1) ? m_sint : m_stmp;
    chk({tag, "/campo"}, 32'(campo), 32'(m_campo));
    chk({tag, "/valor"}, 32'(valor_edicao), 32'(v));
    chk({tag, "/intervalo"}, 32'(intervalo_ligar), 32'(m_int));
    chk({tag, "/tempo"}, 32'(tempo_ligado), 32'(m_tmp));
    chk({tag, "/atualizado"}, 32'(upd_seen), 32'(m_upd));
  endtask

  task automatic press(input bit mo, input bit ma, input bit me, input int hold, input string tag);
    @(negedge clk);
    btn_modo = mo; btn_mais = ma; btn_menos = me;
    repeat (hold) @(negedge clk);
    btn_modo = 0; btn_mais = 0; btn_menos = 0;
    repeat (12) @(negedge clk);
    model_press(mo, ma, me);
    check_all(tag);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    btn_mais = 1;
    repeat (len) @(negedge clk);
    btn_mais = 0;
    repeat (12) @(negedge clk);
    check_all("glitch");
  endtask

  initial begin
    int upd_before;
    reset = 1; btn_modo = 0; btn_mais = 0; btn_menos = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset_int_const", 32'(intervalo_ligar), 32'd10);
    chk("reset_atualizado", 32'(atualizado), 32'd0);
    reset = 0;

    press(0, 1, 0, 8, "mais_exibe");

    // latency: first campo change exactly at edge k+D+2
    @(negedge clk);
    btn_modo = 1;
    @(posedge clk);
    repeat (D + 1) @(posedge clk);
    #1 chk("lat_k5", 32'(campo), 32'd0);
    @(posedge clk);
    #1 chk("lat_k6", 32'(campo), 32'd1);
    repeat (2) @(negedge clk);
    btn_modo = 0;
    repeat (12) @(negedge clk);
    model_press(1, 0, 0);
    check_all("lat_modo");

    for (int i = 0; i < 3; i++) press(0, 1, 0, 8, "edit_mais");
    press(1, 0, 0, 8, "edit_modo");
    press(0, 0, 1, 8, "edit_menos");
    press(1, 0, 0, 8, "edit_commit");
    chk("full_int", 32'(intervalo_ligar), 32'd13);
    chk("full_tmp", 32'(tempo_ligado), 32'd2);
    chk("full_upd", 32'(upd_seen), 32'd1);

    press(1, 0, 0, 5, "sat_enter");
    for (int i = 0; i < 12; i++) press(0, 0, 1, 5, "sat_dn_int");
    press(0, 0, 1, 5, "sat_int_floor");
    chk("sat_int_1", 32'(valor_edicao), 32'd1);
    press(1, 0, 0, 5, "sat_to_tmp");
    for (int i = 0; i < 29; i++) press(0, 1, 0, 5, "sat_up_tmp");
    press(0, 1, 0, 5, "sat_tmp_ceil");
    chk("sat_tmp_31", 32'(valor_edicao), 32'd31);
    for (int i = 0; i < 31; i++) press(0, 0, 1, 5, "sat_dn_tmp");
    press(0, 0, 1, 5, "sat_tmp_floor");
    chk("sat_tmp_0", 32'(valor_edicao), 32'd0);
    press(1, 0, 0, 5, "sat_commit");

    press(1, 0, 0, 5, "deb_enter");
    for (int i = 0; i < 6; i++) glitch($urandom_range(1, D - 1));
    press(0, 1, 0, D, "deb_min_press");
    press(0, 1, 0, 50, "deb_long_press");
    chk("deb_value", 32'(valor_edicao), 32'd3);

    press(0, 1, 1, 6, "sim_mais_menos");
    press(1, 1, 0, 6, "sim_modo_mais");
    press(1, 0, 0, 6, "sim_commit");
    chk("sim_int", 32'(intervalo_ligar), 32'd3);

    press(1, 0, 0, 5, "rst_enter");
    for (int i = 0; i < 17; i++) press(0, 1, 0, 5, "rst_up_int");
    press(1, 0, 0, 5, "rst_to_tmp");
    for (int i = 0; i < 7; i++) press(0, 1, 0, 5, "rst_up_tmp");
    chk("rst_shadow", 32'(valor_edicao), 32'd7);
    upd_before = upd_seen;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    repeat (5) @(negedge clk);
    check_all("rst_mid");
    chk("rst_no_upd", 32'(upd_seen), 32'(upd_before));

    for (int i = 0; i < 60; i++) begin
      int r, h;
      r = $urandom_range(0, 7);
      h = $urandom_range(D, 12);
      case (r)
        0, 1: press(0, 1, 0, h, "rnd_mais");
        2, 3: press(0, 0, 1, h, "rnd_menos");
        4:    press(1, 0, 0, h, "rnd_modo");
        5:    press(0, 1, 1, h, "rnd_both");
        6:    press(1, 0, 1, h, "rnd_modo_menos");
        default: glitch($urandom_range(1, D - 1));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
